// File: rtl/alu_stage_pkg.sv
// Shared opcodes, FSM state type and command layout for the ALU issue stage.
package alu_stage_pkg;

  localparam int OP_W    = 4;
  localparam int SHAMT_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd4;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd5;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd6;
  localparam logic [OP_W-1:0] OP_GT   = 4'd7;
  localparam logic [OP_W-1:0] OP_LT   = 4'd8;
  localparam logic [OP_W-1:0] OP_LAST = 4'd8;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_e;

  localparam int CMD_W = 2*32 + OP_W + SHAMT_W;

  // Command word is {a, b, op, shamt}, MSB first.
  function automatic int cmd_w(input int data_w);
    return 2*data_w + OP_W + SHAMT_W;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap modulo DEPTH (power of two).
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 73
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Full blocks pushes even when a pop happens in the same cycle.
  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: queues ALU commands, drives registered ALU operands, returns results.
// Define ALU_ISSUE_STATS_EN to add the stat_ops/stat_ovf handshake counters.
module alu_issue_stage
  import alu_stage_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_shamt,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_overflow,
  output logic              out_illegal,
  output logic [3:0]        out_op
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]       stat_ops,
  output logic [15:0]       stat_ovf
`endif
);

  localparam int CmdW = cmd_w(DATA_W);

  logic [CmdW-1:0]         fifo_wdata;
  logic [CmdW-1:0]         fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count_unused;
  logic                    have_cmd;
  logic                    load_cmd;
  logic                    out_hs;
  logic                    op_illegal;
  logic                    op_arith;

  state_e                  state_q;
  logic [DATA_W-1:0]       alu_a_q;
  logic [DATA_W-1:0]       alu_b_q;
  logic [3:0]              alu_op_q;
  logic [4:0]              alu_shamt_q;
  logic                    out_valid_q;
  logic [DATA_W-1:0]       out_result_q;
  logic                    out_overflow_q;
  logic                    out_illegal_q;
  logic [3:0]              out_op_q;

  assign fifo_wdata = {in_a, in_b, in_op, in_shamt};
  assign in_ready   = !fifo_full;
  assign have_cmd   = !fifo_empty;
  assign out_hs     = out_valid_q && out_ready;

  // A load pops the FIFO head; it happens from IDLE or on a WAIT handshake.
  assign load_cmd = have_cmd && ((state_q == IDLE) || ((state_q == WAIT) && out_ready));

  assign op_illegal = (alu_op_q > OP_LAST);
  assign op_arith   = (alu_op_q == OP_ADD) || (alu_op_q == OP_SUB);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CmdW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i (fifo_wdata),
    .pop_i   (load_cmd),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      alu_shamt_q    <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
      out_illegal_q  <= 1'b0;
      out_op_q       <= '0;
    end else begin
      if (load_cmd) begin
        alu_a_q     <= fifo_rdata[CmdW-1 -: DATA_W];
        alu_b_q     <= fifo_rdata[OP_W+SHAMT_W +: DATA_W];
        alu_op_q    <= fifo_rdata[SHAMT_W +: OP_W];
        alu_shamt_q <= fifo_rdata[SHAMT_W-1:0];
      end
      case (state_q)
        IDLE: begin
          if (have_cmd) state_q <= EXEC;
        end
        // ALU overflow is only meaningful for add/sub; illegal ops are zeroed.
        EXEC: begin
          out_valid_q    <= 1'b1;
          out_op_q       <= alu_op_q;
          out_illegal_q  <= op_illegal;
          out_result_q   <= op_illegal ? '0 : alu_result;
          out_overflow_q <= op_arith && alu_overflow;
          state_q        <= WAIT;
        end
        WAIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= have_cmd ? EXEC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign alu_shamt    = alu_shamt_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_overflow = out_overflow_q;
  assign out_illegal  = out_illegal_q;
  assign out_op       = out_op_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_ops_q;
  logic [15:0] stat_ovf_q;

  // Op count wraps; overflow count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q <= '0;
      stat_ovf_q <= '0;
    end else if (out_hs) begin
      stat_ops_q <= stat_ops_q + 32'd1;
      if (out_overflow_q && (stat_ovf_q != 16'hFFFF)) stat_ovf_q <= stat_ovf_q + 16'd1;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_ovf = stat_ovf_q;
`else
  logic out_hs_unused;
  assign out_hs_unused = out_hs;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized traffic against a
// result-queue reference model. Stats checks compile in with ALU_ISSUE_STATS_EN.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        ill;
    logic [3:0]  op;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_shamt = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_illegal;
  logic [3:0]  out_op;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_ops;
  logic [15:0] stat_ovf;
`endif

  int          checks = 0;
  int          errors = 0;
  exp_t        expQ[$];
  logic [31:0] seenQ[$];
  exp_t        aluM;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(4), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_op        (in_op),
    .in_shamt     (in_shamt),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_shamt    (alu_shamt),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_illegal  (out_illegal),
    .out_op       (out_op)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_ovf     (stat_ovf)
`endif
  );

  // What the writeback side should receive for one command, from plain signed arithmetic.
  function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] op, input logic [4:0] sh);
    exp_t   e;
    longint sa, sb, wide;
    longint maxS, minS;
    maxS = 64'sd2147483647;
    minS = -64'sd2147483648;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wide = 0;
    e.res = '0;
    e.ovf = 1'b0;
    e.ill = 1'b0;
    e.op  = op;
    case (op)
      4'd0: begin wide = sa + sb; e.res = wide[31:0]; e.ovf = (wide > maxS) || (wide < minS); end
      4'd1: begin wide = sa - sb; e.res = wide[31:0]; e.ovf = (wide > maxS) || (wide < minS); end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a << sh;
      4'd5: e.res = a >> sh;
      4'd6: e.res = $unsigned($signed(a) >>> sh);
      4'd7: e.res = (sa > sb) ? 32'd1 : 32'd0;
      4'd8: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Stand-in ALU: garbage overflow on non-arith ops and garbage result on illegal ops.
  always_comb begin
    aluM = refModel(alu_a, alu_b, alu_op, alu_shamt);
    alu_result = aluM.ill ? 32'hDEADBEEF : aluM.res;
    alu_overflow = (alu_op <= 4'd1) ? aluM.ovf : (alu_a[0] ^ alu_b[1]);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock: score handshakes/pushes seen before the edge, then check hold stability after it.
  task automatic cycle();
    logic        holdPending;
    logic [31:0] holdRes;
    logic [3:0]  holdOp;
    exp_t        e;
    holdPending = out_valid && !out_ready && !rst;
    holdRes = out_result;
    holdOp = out_op;
    if (!rst && out_valid && out_ready) begin
      checkOutput("result_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("result", out_result, e.res);
        checkOutput("overflow", 32'(out_overflow), 32'(e.ovf));
        checkOutput("illegal", 32'(out_illegal), 32'(e.ill));
        checkOutput("op", 32'(out_op), 32'(e.op));
      end
      seenQ.push_back(out_result);
    end
    if (!rst && in_valid && in_ready) expQ.push_back(refModel(in_a, in_b, in_op, in_shamt));
    @(posedge clk);
    @(negedge clk);
    if (holdPending) begin
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_result", out_result, holdRes);
      checkOutput("hold_op", 32'(out_op), 32'(holdOp));
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op, input logic [4:0] sh);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    in_shamt = sh;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      cycle();
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((expQ.size() != 0 || out_valid) && n < 80) begin
      cycle();
      n++;
    end
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] bpExp [5];
    bpExp[0] = 32'd3;
    bpExp[1] = 32'd100;
    bpExp[2] = 32'hFFFFFFFF;
    bpExp[3] = 32'd1;
    bpExp[4] = 32'd0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_out_result", out_result, 32'd0);
    checkOutput("rst_out_op", 32'(out_op), 32'd0);
    rst = 1'b0;

    // Single command latency: valid two edges after the push edge.
    out_ready = 1'b1;
    applyStimulus(32'd12, 32'd15, 4'd0, 5'd0);
    checkOutput("lat_n0_valid", 32'(out_valid), 32'd0);
    cycle();
    checkOutput("lat_n1_valid", 32'(out_valid), 32'd0);
    checkOutput("lat_n1_alu_a", alu_a, 32'd12);
    checkOutput("lat_n1_alu_b", alu_b, 32'd15);
    checkOutput("lat_n1_alu_op", 32'(alu_op), 32'd0);
    cycle();
    checkOutput("lat_n2_valid", 32'(out_valid), 32'd1);
    checkOutput("single_result", out_result, 32'd27);
    checkOutput("single_ovf", 32'(out_overflow), 32'd0);
    checkOutput("single_op", 32'(out_op), 32'd0);
    cycle();
    checkOutput("single_done", 32'(out_valid), 32'd0);

    // Add overflow, then a non-arith op whose ALU overflow must be ignored.
    out_ready = 1'b0;
    applyStimulus(32'h7FFFFFFF, 32'd5, 4'd0, 5'd0);
    waitValid("ovf_add");
    checkOutput("ovf_add_result", out_result, 32'h80000004);
    checkOutput("ovf_add_flag", 32'(out_overflow), 32'd1);
    applyStimulus(32'h7FFFFFFF, 32'd5, 4'd2, 5'd0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    waitValid("ovf_and");
    checkOutput("ovf_and_result", out_result, 32'd5);
    checkOutput("ovf_and_flag", 32'(out_overflow), 32'd0);
    drain();

    // Illegal opcode passes through zeroed and flagged.
    out_ready = 1'b0;
    applyStimulus(32'h1234, 32'h5678, 4'd12, 5'd3);
    waitValid("illegal");
    checkOutput("illegal_flag", 32'(out_illegal), 32'd1);
    checkOutput("illegal_result", out_result, 32'd0);
    checkOutput("illegal_ovf", 32'(out_overflow), 32'd0);
    checkOutput("illegal_op", 32'(out_op), 32'd12);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    applyStimulus(32'hF0, 32'h0F, 4'd3, 5'd0);
    waitValid("legal_after");
    checkOutput("legal_after_flag", 32'(out_illegal), 32'd0);
    checkOutput("legal_after_result", out_result, 32'hFF);
    drain();

    // Backpressure: five pushes fill the FIFO behind one held result.
    out_ready = 1'b0;
    seenQ.delete();
    applyStimulus(32'd1, 32'd2, 4'd0, 5'd0);
    applyStimulus(32'd300, 32'd200, 4'd1, 5'd0);
    applyStimulus(32'hFFFFFFF0, 32'd0, 4'd6, 5'd5);
    applyStimulus(-32'sd13, 32'd20, 4'd8, 5'd0);
    applyStimulus(32'd5555, 32'd999999, 4'd7, 5'd0);
    checkOutput("bp_full_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_held_result", out_result, 32'd3);
    for (int i = 0; i < 3; i++) cycle();
    checkOutput("bp_still_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_a = 32'hABCD;
    in_b = 32'd1;
    in_op = 4'd0;
    out_ready = 1'b1;
    checkOutput("bp_no_comb_ready", 32'(in_ready), 32'd0);
    cycle();
    in_valid = 1'b0;
    drain();
    checkOutput("bp_count", 32'(seenQ.size()), 32'd5);
    for (int i = 0; i < seenQ.size() && i < 5; i++) checkOutput("bp_order", seenQ[i], bpExp[i]);

    // Reset while waiting with two commands still queued.
    out_ready = 1'b0;
    applyStimulus(32'd7, 32'd9, 4'd0, 5'd1);
    applyStimulus(32'd8, 32'd9, 4'd1, 5'd2);
    applyStimulus(32'd9, 32'd9, 4'd3, 5'd3);
    checkOutput("mid_rst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    cycle();
    expQ.delete();
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_alu_a", alu_a, 32'd0);
    checkOutput("mid_rst_alu_b", alu_b, 32'd0);
    checkOutput("mid_rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("mid_rst_alu_shamt", 32'(alu_shamt), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    checkOutput("mid_rst_no_stale", 32'(out_valid), 32'd0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = $urandom;
      in_b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 100));
      in_op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      in_shamt = 5'($urandom);
      cycle();
    end
    drain();

`ifdef ALU_ISSUE_STATS_EN
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checkOutput("stat_ops_rst", stat_ops, 32'd0);
    checkOutput("stat_ovf_rst", 32'(stat_ovf), 32'd0);
    out_ready = 1'b1;
    applyStimulus(32'd1, 32'd2, 4'd0, 5'd0);
    applyStimulus(32'h7FFFFFFF, 32'd1, 4'd0, 5'd0);
    applyStimulus(32'd3, 32'd4, 4'd0, 5'd0);
    drain();
    checkOutput("stat_ops", stat_ops, 32'd3);
    checkOutput("stat_ovf", 32'(stat_ovf), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checkOutput("stat_ops_clear", stat_ops, 32'd0);
    checkOutput("stat_ovf_clear", 32'(stat_ovf), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Command-issue and result-capture stage around the 32-bit ALU.
- Buffers ALU commands (A, B, op, shift_amt) in a small FIFO and drives them onto the ALU input pins from registers, one command at a time.
- Captures Result/overflow into an output register and returns it through a valid/ready handshake to the writeback side.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >= 2)
- DATA_W, 32, operand/result width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command valid
- in_ready  out  1  FIFO can accept (= !full)
- in_a  in  DATA_W  operand A
- in_b  in  DATA_W  operand B
- in_op  in  4  opcode: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 sra, 7 gt, 8 lt
- in_shamt  in  5  shift amount
- alu_a / alu_b  out  DATA_W  registered ALU operands
- alu_op  out  4  registered ALU opcode
- alu_shamt  out  5  registered ALU shift amount
- alu_result  in  DATA_W  ALU Result (combinational from alu_*)
- alu_overflow  in  1  ALU overflow
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  DATA_W  captured result
- out_overflow  out  1  captured overflow
- out_illegal  out  1  opcode was 9..15
- out_op  out  4  opcode of the returned result

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: FIFO empty, state IDLE. All outputs 0, except in_ready=1.
- Reset mid-operation: in-flight and queued commands are discarded.
- Push: when in_valid && in_ready at a clk edge, store {a, b, op, shamt}.
- FIFO full: in_ready=0 even if a pop occurs in the same cycle. No combinational ready path.
- FSM states:
  - IDLE: if FIFO non-empty, load alu_* from head, pop, go EXEC.
  - EXEC: capture alu_result/alu_overflow into out_* regs, set out_valid=1, go WAIT. The ALU has one full cycle to settle.
  - WAIT: out_valid held and out_* stable until out_ready. On handshake: if FIFO non-empty, load next head into alu_* and go EXEC (out_valid=0 that cycle); else go IDLE.
- Latency: push at edge N into an empty FIFO -> alu_* valid after N+1 -> out_valid high after N+2. Throughput is 1 result per 2 cycles at best.
- Signal stability: alu_* registers change only on a load; all four fields change in the same cycle.
- out_overflow: equals alu_overflow only for op 0/1; forced 0 for every other op, since ALU overflow is stale there.
- Illegal op 9..15: ALU output is not trusted. out_result=0, out_overflow=0, out_illegal=1; the command still passes through the handshake normally.
- Simultaneous push and pop (not full): both occur; count is unchanged.
- FIFO pointers wrap modulo DEPTH.
- out_ready while out_valid=0: ignored.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- Defined: adds two outputs.
  - stat_ops[31:0]: increments on each out handshake, wraps.
  - stat_ovf[15:0]: increments on handshake with out_overflow=1, saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package alu_stage_pkg:
  - opcode localparams OP_ADD=0 … OP_LT=8, OP_LAST=8
  - state enum {IDLE, EXEC, WAIT}
  - command field widths and CMD_W = 2*DATA_W+9
- Sub-module alu_cmd_fifo: parameterised synchronous FIFO with push/pop/full/empty and count. The stage instantiates it and owns the FSM and output registers.

Test Plan:
- Single command: push A=12, B=15, op=0, out_ready=1 -> out_valid 2 cycles later; out_result=27, out_overflow=0, out_op=0.
- Add overflow then non-arith: push A=32'h7FFFFFFF, B=5, op=0 -> out_result=32'h80000004, out_overflow=1. Next push op=2 -> out_overflow=0.
- Backpressure: out_ready=0, push 5 commands (DEPTH=4) -> in_ready=0 after the FIFO fills. out_result holds the first result unchanged. Release out_ready -> all results return in order: sub 300-200=100, sra 32'hFFFFFFF0>>>5=32'hFFFFFFFF, lt -13<20=1, gt 5555>999999=0.
- Illegal op: push op=12 -> out_illegal=1, out_result=0, out_overflow=0; next legal op returns out_illegal=0.
- Reset mid-op: assert rst in WAIT with 2 queued -> next cycle out_valid=0, in_ready=1, alu_*=0; no stale result emerges after reset release.
- Stats (ALU_ISSUE_STATS_EN): 3 adds with 1 overflow -> stat_ops=3, stat_ovf=1; rst clears both.
